// File: rtl/spectrum_peak.sv
// Streaming FFT-frame peak detector: per-bin power, frame-wide argmax,
// threshold flag and frame-length check, handed out via valid/ready.
module spectrum_peak #(
  parameter int N_BINS = 16,
  parameter int W = 16,
  parameter int LANES = 4,
  localparam int IW = $clog2(N_BINS),
  localparam int PW = 2 * W,
  localparam int BEATS = N_BINS / LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES*W-1:0] in_re,
  input  logic [LANES*W-1:0] in_im,
  input  logic             in_last,
  input  logic [PW-1:0]    thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    freq,
  output logic [PW-1:0]    peak_pow,
  output logic             peak_found,
  output logic             frame_err
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

  state_t state_q, state_d;

  logic          accept;
  logic          term;
  logic          last_beat;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] pow [LANES];

  logic          s1_valid;
  logic          s1_term;
  logic          s1_err;
  logic [PW-1:0] s1_pow [LANES];
  logic [IW-1:0] s1_base;

  logic [PW-1:0] best_pow;
  logic [IW-1:0] best_idx;

  logic [PW-1:0] run_pow;
  logic [IW-1:0] run_idx;
  logic          run_first;
  logic          s2_term;
  logic          s2_err;

  function automatic logic [PW-1:0] power(
    input logic signed [W-1:0] re,
    input logic signed [W-1:0] im
  );
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    rr = PW'(re) * PW'(re);
    ii = PW'(im) * PW'(im);
    return $unsigned(rr) + $unsigned(ii);
  endfunction

  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign term      = in_last || last_beat;
  assign in_ready  = rst && (state_q == ACC);
  assign accept    = in_valid && in_ready;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      pow[j] = power(in_re[j*W +: W], in_im[j*W +: W]);
    end
  end

  // strict compare keeps the lower lane on ties
  always_comb begin
    best_pow = s1_pow[0];
    best_idx = s1_base;
    for (int j = 1; j < LANES; j++) begin
      if (s1_pow[j] > best_pow) begin
        best_pow = s1_pow[j];
        best_idx = s1_base + IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_term  <= 1'b0;
      s1_err   <= 1'b0;
      s1_base  <= '0;
      beat_cnt <= '0;
      for (int j = 0; j < LANES; j++) s1_pow[j] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int j = 0; j < LANES; j++) s1_pow[j] <= pow[j];
        s1_base  <= IW'(int'(beat_cnt) * LANES);
        s1_term  <= term;
        s1_err   <= (in_last != last_beat);
        beat_cnt <= term ? '0 : beat_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_pow    <= '0;
      run_idx    <= '0;
      run_first  <= 1'b1;
      s2_term    <= 1'b0;
      s2_err     <= 1'b0;
      out_valid  <= 1'b0;
      freq       <= '0;
      peak_pow   <= '0;
      peak_found <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      s2_term <= s1_valid && s1_term;
      if (s1_valid) begin
        if (run_first || best_pow > run_pow) begin
          run_pow <= best_pow;
          run_idx <= best_idx;
        end
        run_first <= 1'b0;
        s2_err    <= s1_err;
      end
      if (s2_term) begin
        freq       <= run_idx;
        peak_pow   <= run_pow;
        peak_found <= (run_pow >= thresh);
        frame_err  <= s2_err;
        out_valid  <= 1'b1;
        run_pow    <= '0;
        run_idx    <= '0;
        run_first  <= 1'b1;
      end else if (state_q == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ACC;
    else      state_q <= state_d;
  end

  // DRAIN covers the two pipeline stages behind the terminal beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (accept && term) state_d = DRAIN;
      DRAIN:   if (s2_term) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

endmodule

// File: tb/tb_spectrum_peak.sv
// Bench for spectrum_peak: directed corner frames plus random frames
// checked against a per-frame argmax model.
module tb_spectrum_peak;

  localparam int N_BINS = 16;
  localparam int W = 16;
  localparam int LANES = 4;
  localparam int IW = 4;
  localparam int PW = 32;
  localparam int BEATS = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*W-1:0] in_re = '0;
  logic [LANES*W-1:0] in_im = '0;
  logic               in_last = 1'b0;
  logic [PW-1:0]      thresh = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [IW-1:0]      freq;
  logic [PW-1:0]      peak_pow;
  logic               peak_found;
  logic               frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fr_re [N_BINS];
  int fr_im [N_BINS];

  spectrum_peak #(.N_BINS(N_BINS), .W(W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .freq(freq), .peak_pow(peak_pow),
    .peak_found(peak_found), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N_BINS; i++) begin
      if (mode == 0) begin
        fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
        fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        fr_re[i] = int'($urandom_range(0, 4)) - 2;
        fr_im[i] = int'($urandom_range(0, 4)) - 2;
      end
    end
  endtask

  task automatic drive_beat(input int b);
    int t;
    for (int j = 0; j < LANES; j++) begin
      t = fr_re[b*LANES + j];
      in_re[j*W +: W] = t[W-1:0];
      t = fr_im[b*LANES + j];
      in_im[j*W +: W] = t[W-1:0];
    end
  endtask

  // th_in < 0 picks a threshold right around the expected peak
  task automatic run_frame(input int last_at, input longint th_in,
                           input int hold, input bit gaps,
                           input bit rst_hold);
    int     nb;
    int     bi;
    longint best;
    longint p;
    longint th;
    bit     err;
    bit     fnd;
    nb  = ((last_at < BEATS - 1) ? last_at : BEATS - 1) + 1;
    err = (last_at != BEATS - 1);
    best = -1;
    bi   = 0;
    for (int i = 0; i < nb * LANES; i++) begin
      p = longint'(fr_re[i]) * longint'(fr_re[i])
        + longint'(fr_im[i]) * longint'(fr_im[i]);
      if (p > best) begin
        best = p;
        bi   = i;
      end
    end
    th = th_in;
    if (th < 0) begin
      th = best + longint'($urandom_range(0, 2)) - 1;
      if (th < 0) th = 0;
    end
    fnd = (best >= th);
    thresh = th[PW-1:0];
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          in_re    = {$urandom, $urandom};
          in_im    = {$urandom, $urandom};
          tick();
        end
      end
      in_valid = 1'b1;
      in_last  = (b == last_at);
      drive_beat(b);
      chk("ready_acc", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ready_drain", in_ready, 0);
    chk("ov_k", out_valid, 0);
    tick();
    chk("ov_k1", out_valid, 0);
    tick();
    chk("ov_k2", out_valid, 1);
    chk("freq", freq, bi);
    chk("peak_pow", peak_pow, best);
    chk("peak_found", peak_found, fnd);
    chk("frame_err", frame_err, err);
    repeat (hold) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_re    = {$urandom, $urandom};
      tick();
      chk("hold_ov", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_freq", freq, bi);
      chk("hold_pow", peak_pow, best);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rst_hold) begin
      rst = 1'b0;
      tick();
      chk("rsth_ov", out_valid, 0);
      chk("rsth_freq", freq, 0);
      chk("rsth_pow", peak_pow, 0);
      chk("rsth_ready", in_ready, 0);
      rst = 1'b1;
      tick();
      chk("rsth_ov_after", out_valid, 0);
      chk("rsth_ready_after", in_ready, 1);
    end else begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ov_clr", out_valid, 0);
      chk("ready_back", in_ready, 1);
      chk("keep_freq", freq, bi);
      chk("keep_pow", peak_pow, best);
      chk("keep_err", frame_err, err);
    end
  endtask

  initial begin
    int r;
    int la;
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_freq", freq, 0);
    chk("rst_pow", peak_pow, 0);
    chk("rst_found", peak_found, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("rel_ready", in_ready, 1);

    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = 1;
      fr_im[i] = 0;
    end
    fr_re[9] = 100;
    run_frame(3, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    fr_re[3]  = 5;
    fr_im[3]  = 5;
    fr_re[12] = 7;
    fr_im[12] = 1;
    run_frame(3, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    fr_re[15] = -32768;
    fr_im[15] = -32768;
    run_frame(3, 64'd2147483649, 0, 1'b0, 1'b0);

    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = int'($urandom_range(0, 100));
      fr_im[i] = int'($urandom_range(0, 100));
    end
    fr_re[13] = 30000;
    run_frame(2, 0, 0, 1'b0, 1'b0);
    fill(0);
    run_frame(3, 0, 0, 1'b0, 1'b0);

    fill(0);
    run_frame(3, -1, 5, 1'b0, 1'b0);

    for (int i = 0; i < N_BINS; i++) begin
      fr_re[i] = 30000;
      fr_im[i] = -30000;
    end
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      drive_beat(b);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_pow", peak_pow, 0);
    chk("mid_rst_found", peak_found, 0);
    chk("mid_rst_err", frame_err, 0);
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("mid_rst_no_ov", out_valid, 0);
    end
    fill(1);
    run_frame(3, -1, 0, 1'b0, 1'b0);

    fill(0);
    run_frame(3, -1, 2, 1'b1, 1'b1);

    for (int k = 0; k < 24; k++) begin
      fill(k % 2);
      r  = int'($urandom_range(0, 6));
      la = (r < 4) ? r : ((r == 4) ? 99 : 3);
      run_frame(la, -1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
